// File: rtl/spi_slave_device.sv
// SPI mode-0 responder, pins oversampled in SYS_CLK; define SPI_SLAVE_ERR_EN to build sticky ERR flags.
// Latency: last SCK rise -> RX_VALID in SYNC_STAGES+2 cycles; TX_LOAD taken only while TX_READY, RX has no backpressure.
module spi_slave_device #(
  parameter int                   DATA_BITS   = 16,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [DATA_BITS-1:0] TX_DEFAULT  = '0
) (
  input  logic                 SYS_CLK,
  input  logic                 reset,
  input  logic                 SCK,
  input  logic                 CSbar,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 MISO_OE,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_LOAD,
  output logic                 TX_READY,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic [1:0]           ERR,
  input  logic                 ERR_CLR
);

  localparam int CNT_W = $clog2(DATA_BITS);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  logic [DATA_BITS-1:0]   tx_buf, tx_shift, next_word;
  logic                   buf_full;
  logic [DATA_BITS-2:0]   rx_shift;
  logic [CNT_W-1:0]       cnt, cnt_after;
  logic                   rx_pend;
  logic                   load_word, close, shift_rise, shift_fall, reload, consume;
  logic                   load_acc, word_done, frame_err, underrun_evt;

  // CSbar chain resets low: a frame cut by reset is never re-entered mid-word,
  // the responder waits for CSbar to go high and fall again.
  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CSbar};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_d;
  assign sck_fall = ~sck_s &  sck_d;
  assign cs_fall  = ~cs_s  &  cs_d;
  assign cs_rise  =  cs_s  & ~cs_d;

  always_ff @(posedge SYS_CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_word = 1'b0;
    close     = 1'b0;
    case (state)
      IDLE:    if (cs_fall) state_nxt = LOAD;
      LOAD: begin
        load_word = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: if (cs_rise) begin
        close     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign shift_rise   = (state == SHIFT) & sck_rise;
  assign shift_fall   = (state == SHIFT) & sck_fall & ~cs_rise;
  assign word_done    = shift_rise & (cnt == CNT_W'(DATA_BITS - 1));
  assign cnt_after    = word_done ? '0 : (shift_rise ? cnt + CNT_W'(1) : cnt);
  // The SCK edge in a closing cycle counts before the frame check.
  assign frame_err    = close & (cnt_after != '0);
  assign reload       = shift_fall & (cnt == '0);
  assign consume      = load_word | reload;
  assign underrun_evt = consume & ~buf_full;
  assign load_acc     = TX_LOAD & ~buf_full;
  assign next_word    = buf_full ? tx_buf : TX_DEFAULT;

  assign TX_READY = ~buf_full;
  assign MISO     = tx_shift[DATA_BITS-1];

  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      tx_buf   <= '0;
      buf_full <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      cnt      <= '0;
      rx_pend  <= 1'b0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      MISO_OE  <= 1'b0;
    end else begin
      rx_pend  <= word_done;
      RX_VALID <= rx_pend;

      // A load coinciding with consumption of an empty buffer is kept for the next word.
      if (load_acc) begin
        tx_buf   <= TX_DATA;
        buf_full <= 1'b1;
      end else if (consume) begin
        buf_full <= 1'b0;
      end

      if (shift_rise) begin
        rx_shift <= {rx_shift[DATA_BITS-3:0], mosi_s};
        cnt      <= cnt_after;
      end
      if (word_done) RX_DATA <= {rx_shift, mosi_s};

      if (consume)
        tx_shift <= next_word;
      else if (shift_fall && cnt != '0)
        tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};

      if (load_word) begin
        MISO_OE <= 1'b1;
        cnt     <= '0;
      end
      if (close) begin
        MISO_OE  <= 1'b0;
        tx_shift <= '0;
        cnt      <= '0;
      end
    end
  end

`ifdef SPI_SLAVE_ERR_EN
  logic [1:0] err_q;

  // Set events are applied after the clear so they win.
  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      err_q <= 2'b00;
    end else begin
      if (ERR_CLR)      err_q    <= 2'b00;
      if (underrun_evt) err_q[0] <= 1'b1;
      if (frame_err)    err_q[1] <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  logic err_unused;
  assign err_unused = ^{ERR_CLR, underrun_evt, frame_err};
  assign ERR        = 2'b00;
`endif

endmodule

// File: tb/tb_spi_slave_device.sv
// Directed bench for spi_slave_device: table of single-word frames plus hand sequences
// for back-to-back words, aborted frame, reset mid-frame and RX_VALID latency.
module tb_spi_slave_device;

  logic        SYS_CLK = 1'b0;
  logic        reset, SCK, CSbar, MOSI, MISO, MISO_OE;
  logic [15:0] TX_DATA, RX_DATA;
  logic        TX_LOAD, TX_READY, RX_VALID, ERR_CLR;
  logic [1:0]  ERR;

`ifdef SPI_SLAVE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int rx_pulses = 0;
  int oe_low = 0;

  spi_slave_device #(.DATA_BITS(16), .SYNC_STAGES(2), .TX_DEFAULT(16'h0000)) dut (
    .SYS_CLK (SYS_CLK),
    .reset   (reset),
    .SCK     (SCK),
    .CSbar   (CSbar),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .MISO_OE (MISO_OE),
    .TX_DATA (TX_DATA),
    .TX_LOAD (TX_LOAD),
    .TX_READY(TX_READY),
    .RX_DATA (RX_DATA),
    .RX_VALID(RX_VALID),
    .ERR     (ERR),
    .ERR_CLR (ERR_CLR)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  always @(negedge SYS_CLK) if (RX_VALID === 1'b1) rx_pulses++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        do_load;
    logic        dbl_load;
    logic [15:0] tx;
    logic [15:0] mosi;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic tick(input int n);
    repeat (n) @(posedge SYS_CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    TX_DATA = w;
    TX_LOAD = 1'b1;
    tick(1);
    TX_LOAD = 1'b0;
  endtask

  task automatic err_clear();
    ERR_CLR = 1'b1;
    tick(1);
    ERR_CLR = 1'b0;
    tick(1);
  endtask

  // Master at SYS_CLK/8: MOSI set with SCK low, MISO sampled at SCK rise.
  task automatic shift_bits(input logic [31:0] mosi_w, input int nbits, input bit mid_load,
                            input logic [15:0] mid_w, output logic [31:0] miso_w);
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      SCK  = 1'b0;
      MOSI = mosi_w[nbits-1-i];
      tick(4);
      SCK = 1'b1;
      miso_w[nbits-1-i] = MISO;
      if (MISO_OE !== 1'b1) oe_low++;
      if (mid_load && i == 4) begin
        load_word(mid_w);
        tick(3);
      end else begin
        tick(4);
      end
    end
  endtask

  // CSbar rises while SCK is still high; the trailing SCK fall lands outside the frame.
  task automatic frame(input logic [31:0] mosi_w, input int nbits, input bit mid_load,
                       input logic [15:0] mid_w, output logic [31:0] miso_w);
    oe_low = 0;
    CSbar  = 1'b0;
    tick(8);
    shift_bits(mosi_w, nbits, mid_load, mid_w, miso_w);
    CSbar = 1'b1;
    tick(4);
    SCK = 1'b0;
    tick(8);
  endtask

  initial begin
    logic [31:0] miso_w;
    logic        last_miso;
    int          p0;

    vecs[0] = '{do_load: 1'b1, dbl_load: 1'b1, tx: 16'hA5C3, mosi: 16'h1234,
                exp_miso: 16'hA5C3, exp_rx: 16'h1234, exp_err: 2'b00};
    vecs[1] = '{do_load: 1'b0, dbl_load: 1'b0, tx: 16'h0000, mosi: 16'h5AF0,
                exp_miso: 16'h0000, exp_rx: 16'h5AF0, exp_err: {1'b0, ERR_EN}};
    vecs[2] = '{do_load: 1'b1, dbl_load: 1'b0, tx: 16'hFFFF, mosi: 16'h0000,
                exp_miso: 16'hFFFF, exp_rx: 16'h0000, exp_err: 2'b00};
    vecs[3] = '{do_load: 1'b1, dbl_load: 1'b1, tx: 16'h8001, mosi: 16'hFFFF,
                exp_miso: 16'h8001, exp_rx: 16'hFFFF, exp_err: 2'b00};

    reset = 1'b1; SCK = 1'b0; CSbar = 1'b1; MOSI = 1'b0;
    TX_DATA = '0; TX_LOAD = 1'b0; ERR_CLR = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(6);
    chk("reset_tx_ready", 32'(TX_READY), 32'd1);
    chk("reset_miso_oe",  32'(MISO_OE),  32'd0);
    chk("reset_miso",     32'(MISO),     32'd0);
    chk("reset_rx_valid", 32'(RX_VALID), 32'd0);
    chk("reset_rx_data",  32'(RX_DATA),  32'd0);
    chk("reset_err",      32'(ERR),      32'd0);

    for (int v = 0; v < 4; v++) begin
      err_clear();
      if (vecs[v].do_load) begin
        load_word(vecs[v].tx);
        chk($sformatf("v%0d_tx_ready_busy", v), 32'(TX_READY), 32'd0);
        if (vecs[v].dbl_load) load_word(16'h5555);
      end
      p0 = rx_pulses;
      frame({16'h0, vecs[v].mosi}, 16, 1'b0, 16'h0, miso_w);
      chk($sformatf("v%0d_miso_stream", v), miso_w, {16'h0, vecs[v].exp_miso});
      chk($sformatf("v%0d_rx_data", v), 32'(RX_DATA), 32'(vecs[v].exp_rx));
      chk($sformatf("v%0d_rx_pulses", v), 32'(rx_pulses - p0), 32'd1);
      chk($sformatf("v%0d_err", v), 32'(ERR), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_tx_ready", v), 32'(TX_READY), 32'd1);
      chk($sformatf("v%0d_oe_in_frame", v), 32'(oe_low), 32'd0);
      chk($sformatf("v%0d_oe_after", v), 32'({MISO_OE, MISO}), 32'd0);
    end

    // Back-to-back: second word loaded during the first.
    err_clear();
    load_word(16'h0001);
    p0 = rx_pulses;
    frame(32'hCAFE_0F0F, 32, 1'b1, 16'h0002, miso_w);
    chk("b2b_miso_stream", miso_w, 32'h0001_0002);
    chk("b2b_rx_pulses", 32'(rx_pulses - p0), 32'd2);
    chk("b2b_rx_data", 32'(RX_DATA), 32'h0F0F);
    chk("b2b_err", 32'(ERR), 32'd0);

    // Aborted frame after 7 bits.
    err_clear();
    load_word(16'h0F0F);
    p0 = rx_pulses;
    frame(32'h55, 7, 1'b0, 16'h0, miso_w);
    chk("abort_rx_pulses", 32'(rx_pulses - p0), 32'd0);
    chk("abort_rx_data", 32'(RX_DATA), 32'h0F0F);
    chk("abort_err", 32'(ERR), 32'({ERR_EN, 1'b0}));
    chk("abort_oe_after", 32'({MISO_OE, MISO}), 32'd0);
    err_clear();
    chk("abort_err_clr", 32'(ERR), 32'd0);
    load_word(16'h1357);
    p0 = rx_pulses;
    frame(32'h2468, 16, 1'b0, 16'h0, miso_w);
    chk("post_abort_miso", miso_w, 32'h1357);
    chk("post_abort_rx_data", 32'(RX_DATA), 32'h2468);
    chk("post_abort_pulses", 32'(rx_pulses - p0), 32'd1);
    chk("post_abort_err", 32'(ERR), 32'd0);

    // Reset at bit 9 with CSbar held low.
    load_word(16'h7777);
    p0 = rx_pulses;
    CSbar = 1'b0;
    tick(8);
    shift_bits(32'h1FF, 9, 1'b0, 16'h0, miso_w);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("rst_mid_tx_ready", 32'(TX_READY), 32'd1);
    chk("rst_mid_oe",       32'({MISO_OE, MISO}), 32'd0);
    chk("rst_mid_rx_valid", 32'(RX_VALID), 32'd0);
    chk("rst_mid_rx_data",  32'(RX_DATA), 32'd0);
    chk("rst_mid_err",      32'(ERR), 32'd0);
    shift_bits(32'hFF, 8, 1'b0, 16'h0, miso_w);
    CSbar = 1'b1;
    tick(4);
    SCK = 1'b0;
    tick(8);
    chk("rst_mid_no_pulse", 32'(rx_pulses - p0), 32'd0);
    chk("rst_mid_oe_idle",  32'(MISO_OE), 32'd0);

    // BEEF frame with RX_VALID latency measured from the last SCK rise.
    load_word(16'h1111);
    p0 = rx_pulses;
    oe_low = 0;
    CSbar = 1'b0;
    tick(8);
    shift_bits(32'h5F77, 15, 1'b0, 16'h0, miso_w);
    SCK  = 1'b0;
    MOSI = 1'b1;
    tick(4);
    SCK = 1'b1;
    last_miso = MISO;
    tick(3);
    chk("lat_before", 32'(RX_VALID), 32'd0);
    tick(1);
    chk("lat_exact", 32'(RX_VALID), 32'd1);
    tick(1);
    chk("lat_single", 32'(RX_VALID), 32'd0);
    CSbar = 1'b1;
    tick(4);
    SCK = 1'b0;
    tick(8);
    chk("beef_rx_data", 32'(RX_DATA), 32'hBEEF);
    chk("beef_miso", 32'({miso_w[14:0], last_miso}), 32'h1111);
    chk("beef_pulses", 32'(rx_pulses - p0), 32'd1);
    chk("beef_err", 32'(ERR), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
